// File: rtl/mem_dma_if.sv
// mem_dma_if: native memory bus (valid/addr/wdata/wstrb/rdata/ready) between initiator and responder
interface mem_dma_if;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  modport master (output mem_valid, mem_addr, mem_wdata, mem_wstrb, input mem_rdata, mem_ready);
  modport slave  (input mem_valid, mem_addr, mem_wdata, mem_wstrb, output mem_rdata, mem_ready);
endinterface

// File: rtl/mem_dma.sv
// mem_dma: block copy / constant fill bus initiator with fully registered outputs
module mem_dma #(
  parameter int LEN_BITS = 16
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start_i,
  input  logic                mode_i,
  input  logic [31:0]         src_addr_i,
  input  logic [31:0]         dst_addr_i,
  input  logic [LEN_BITS-1:0] len_words_i,
  input  logic [31:0]         fill_data_i,
  output logic                busy_o,
  output logic                done_o,
  mem_dma_if.master           mem
);
  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
  state_t              state_q;
  logic [29:0]         src_q, dst_q, src_d, dst_d;
  logic [LEN_BITS-1:0] rem_q;
  logic                mode_q, valid_q, busy_q, done_q, hs;
  logic [31:0]         addr_q, wdata_q;
  logic [3:0]          wstrb_q;
  logic                unused_lsbs;
  assign unused_lsbs = ^{src_addr_i[1:0], dst_addr_i[1:0]};
  assign hs = valid_q && mem.mem_ready;
  assign src_d = src_q + 30'd1;
  assign dst_d = dst_q + 30'd1;
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign mem.mem_valid = valid_q;
  assign mem.mem_addr = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign mem.mem_wstrb = wstrb_q;
  // Transfer sequencer; each transition also loads the next request's bus fields so outputs come straight from flops
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      mode_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (start_i) begin
          src_q   <= src_addr_i[31:2];
          dst_q   <= dst_addr_i[31:2];
          rem_q   <= len_words_i;
          mode_q  <= mode_i;
          wdata_q <= fill_data_i;
          busy_q  <= 1'b1;
          if (len_words_i == '0) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= mode_i ? WR : RD;
            valid_q <= 1'b1;
            addr_q  <= {mode_i ? dst_addr_i[31:2] : src_addr_i[31:2], 2'b00};
            wstrb_q <= {4{mode_i}};
          end
        end
        RD: if (hs) begin
          wdata_q <= mem.mem_rdata;
          src_q   <= src_d;
          state_q <= WR;
          addr_q  <= {dst_q, 2'b00};
          wstrb_q <= 4'hf;
        end
        WR: if (hs) begin
          dst_q <= dst_d;
          rem_q <= rem_q - LEN_BITS'(1);
          if (rem_q == LEN_BITS'(1)) begin
            state_q <= DONE;
            valid_q <= 1'b0;
            done_q  <= 1'b1;
            wstrb_q <= 4'h0;
          end else if (mode_q) begin
            addr_q <= {dst_d, 2'b00};
          end else begin
            state_q <= RD;
            addr_q  <= {src_q, 2'b00};
            wstrb_q <= 4'h0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_dma.sv
// tb_mem_dma: directed and random transfers against a RAM responder and a word-level reference model
module tb_mem_dma;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start_i = 1'b0;
  logic        mode_i = 1'b0;
  logic [31:0] src_addr_i = '0;
  logic [31:0] dst_addr_i = '0;
  logic [15:0] len_words_i = '0;
  logic [31:0] fill_data_i = '0;
  logic        busy_o, done_o;
  int          tests = 0;
  int          fails = 0;

  mem_dma_if bus ();

  mem_dma #(.LEN_BITS(16)) dut (
    .clk(clk), .resetn(resetn), .start_i(start_i), .mode_i(mode_i),
    .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i), .len_words_i(len_words_i),
    .fill_data_i(fill_data_i), .busy_o(busy_o), .done_o(done_o), .mem(bus.master)
  );

  always #5 clk = ~clk;

  // RAM responder: 1024 words aliased by address bits [11:2], ready after stall_n wait cycles per request
  logic [31:0] ram [1024];
  logic [31:0] ref_mem [1024];
  logic [67:0] log_q [$];
  logic [67:0] exp_q [$];
  int unsigned stall_n = 0;
  int unsigned wcnt = 0;
  int          stab_err = 0;
  logic        pstall = 1'b0;
  logic [67:0] pf = '0;

  assign bus.mem_ready = bus.mem_valid && (wcnt >= stall_n);
  assign bus.mem_rdata = ram[bus.mem_addr[11:2]];

  always @(posedge clk) begin
    if (pstall && {bus.mem_addr, bus.mem_wstrb, bus.mem_wdata} !== pf) stab_err++;
    pstall = resetn && bus.mem_valid && !bus.mem_ready;
    pf = {bus.mem_addr, bus.mem_wstrb, bus.mem_wdata};
    if (bus.mem_valid && bus.mem_ready) begin
      log_q.push_back({bus.mem_addr, bus.mem_wstrb, (bus.mem_wstrb == 4'hf) ? bus.mem_wdata : 32'h0});
      if (bus.mem_wstrb == 4'hf) ram[bus.mem_addr[11:2]] = bus.mem_wdata;
      wcnt = 0;
    end else if (bus.mem_valid) wcnt++;
    else wcnt = 0;
  end

  task automatic check(input string tag, input logic [67:0] obs, input logic [67:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: word-by-word ascending transfer, producing the expected bus transaction list
  task automatic model(input logic m, input logic [31:0] s, input logic [31:0] d, input int n, input logic [31:0] f);
    logic [29:0] sw, dw;
    logic [31:0] v;
    sw = s[31:2];
    dw = d[31:2];
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      v = m ? f : ref_mem[sw[9:0]];
      if (!m) exp_q.push_back({sw, 2'b00, 4'h0, 32'h0});
      exp_q.push_back({dw, 2'b00, 4'hf, v});
      ref_mem[dw[9:0]] = v;
      sw = sw + 30'd1;
      dw = dw + 30'd1;
    end
  endtask

  task automatic compare_log(input string tag);
    int bad;
    check({tag, "_nreq"}, 68'(log_q.size()), 68'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check({tag, "_req"}, (i < log_q.size()) ? log_q[i] : 68'hx, exp_q[i]);
    bad = 0;
    for (int i = 0; i < 1024; i++) if (ram[i] !== ref_mem[i]) bad++;
    check({tag, "_ram"}, 68'(bad), 68'd0);
  endtask

  task automatic run(input string tag, input logic m, input logic [31:0] s, input logic [31:0] d,
                     input logic [15:0] n, input logic [31:0] f, input int unsigned st, input int inj);
    int cyc, done_cyc, dones, vcyc, exp_bus;
    stall_n = st;
    log_q.delete();
    model(m, s, d, int'(n), f);
    exp_bus = (m ? int'(n) : 2 * int'(n)) * int'(st + 1);
    @(negedge clk);
    mode_i = m; src_addr_i = s; dst_addr_i = d; len_words_i = n; fill_data_i = f; start_i = 1'b1;
    @(posedge clk);
    cyc = 0; done_cyc = -1; dones = 0; vcyc = 0;
    while (cyc < 2000) begin
      @(negedge clk);
      cyc++;
      start_i = 1'b0;
      if (done_cyc > 0 && cyc == done_cyc + 1) break;
      if (bus.mem_valid) vcyc++;
      if (done_o) begin dones++; done_cyc = cyc; end
      if (cyc == inj) begin
        start_i = 1'b1; mode_i = ~m; dst_addr_i = $urandom; src_addr_i = $urandom;
        len_words_i = 16'($urandom_range(1, 9)); fill_data_i = $urandom;
      end
    end
    check({tag, "_timeout"}, 68'(cyc < 2000), 68'd1);
    check({tag, "_dones"}, 68'(dones), 68'd1);
    check({tag, "_done_cyc"}, 68'(done_cyc), 68'(exp_bus + 1));
    check({tag, "_valid_cycles"}, 68'(vcyc), 68'(exp_bus));
    check({tag, "_idle"}, {66'd0, busy_o, done_o}, 68'd0);
    check({tag, "_stable"}, 68'(stab_err), 68'd0);
    compare_log(tag);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin ram[i] = $urandom; ref_mem[i] = ram[i]; end
    for (int i = 0; i < 4; i++) begin ram[64 + i] = 32'hA0A0_0000 + i; ref_mem[64 + i] = ram[64 + i]; end
    repeat (3) @(negedge clk);
    check("reset_ctrl", {66'd0, busy_o, done_o}, 68'd0);
    check("reset_bus", {bus.mem_valid, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb}, 68'd0);
    resetn = 1'b1;
    run("copy4", 1'b0, 32'h100, 32'h200, 16'd4, 32'h0, 0, -1);
    for (int i = 0; i < 4; i++) check("copy4_dst", 68'(ram[128 + i]), 68'(32'hA0A0_0000 + i));
    run("fill_wrap", 1'b1, 32'h0, 32'hFFFF_FFFE, 16'd3, 32'hDEAD_BEEF, 0, -1);
    check("fill_wrap_a0", 68'(ram[1023]), 68'hDEAD_BEEF);
    check("fill_wrap_a2", 68'(ram[1]), 68'hDEAD_BEEF);
    run("len0", 1'b0, 32'h40, 32'h80, 16'd0, 32'h0, 0, -1);
    run("copy_stall", 1'b0, 32'h104, 32'h304, 16'd2, 32'h0, 3, -1);
    check("copy_stall_dst", 68'(ram[193]), 68'(32'hA0A0_0001));
    run("fill_busy_start", 1'b1, 32'h0, 32'h400, 16'd5, 32'h1234_5678, 0, 2);
    stall_n = 0;
    log_q.delete();
    @(negedge clk);
    mode_i = 1'b0; src_addr_i = 32'h100; dst_addr_i = 32'h600; len_words_i = 16'd4; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_in_wr2", {bus.mem_valid, bus.mem_addr, bus.mem_wstrb}, {1'b1, 32'h604, 4'hf});
    resetn = 1'b0;
    @(negedge clk);
    check("abort_outputs", {65'd0, bus.mem_valid, busy_o, done_o}, 68'd0);
    resetn = 1'b1;
    model(1'b0, 32'h100, 32'h600, 2, 32'h0);
    compare_log("abort");
    run("after_abort", 1'b0, 32'h100, 32'h700, 16'd4, 32'h0, 1, -1);
    for (int k = 0; k < 10; k++) begin
      logic [15:0] n;
      n = 16'($urandom_range(0, 6));
      run("rand", 1'($urandom_range(0, 1)), $urandom, $urandom, n, $urandom,
          $urandom_range(0, 2), (n != 0 && k[0]) ? 1 : -1);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_dma.md
Name: mem_dma

Overview:
- Bus initiator for the SoC's native memory interface (valid/addr/wdata/wstrb/rdata/ready): the requesting side that the on-chip RAM and peripherals answer.
- Copy mode: moves a block of 32-bit words from a source region to a destination region.
- Fill mode: writes a constant word across a destination region.
- Sits beside the CPU on the SoC interconnect; used for fast memory scrubbing and buffer moves without CPU load/store loops.

Parameters:
- LEN_BITS, 16, width of the word-count field; max transfer 2^LEN_BITS-1 words.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset, synchronous, active-low.
- start  in  1  request a transfer; sampled only in IDLE.
- mode  in  1  0 = copy, 1 = fill.
- src_addr  in  32  source byte address; bits [1:0] ignored.
- dst_addr  in  32  destination byte address; bits [1:0] ignored.
- len_words  in  LEN_BITS  number of words to transfer.
- fill_data  in  32  word written in fill mode.
- busy  out  1  high from the cycle after start is accepted until return to IDLE.
- done  out  1  one-cycle completion pulse.
- mem_valid  out  1  request valid.
- mem_addr  out  32  word-aligned request address; [1:0] always 00.
- mem_wdata  out  32  write data.
- mem_wstrb  out  4  0000 = read, 1111 = write.
- mem_rdata  in  32  read data; valid when mem_ready is high.
- mem_ready  in  1  responder ready; may be combinational from mem_valid, same cycle.

Behaviour:
- Clock and reset: clk, resetn synchronous active-low. In reset, state=IDLE and all outputs are 0 (busy, done, mem_valid, mem_addr, mem_wdata, mem_wstrb).
- Output timing: all outputs decode from flops only. No combinational path from start, mem_ready or mem_rdata to any output.
- Handshake: a transaction completes at the rising edge where mem_valid && mem_ready. Until then mem_addr, mem_wdata and mem_wstrb are held stable. Requests may be back-to-back: mem_valid stays high and the next request's fields appear in the cycle after the completing edge.
- Start acceptance: on an edge with state=IDLE and start=1, latch src[31:2], dst[31:2], len, mode and fill_data into internal registers. If len=0, go to DONE with no bus activity; else copy -> RD, fill -> WR.
- RD: mem_valid=1, mem_wstrb=0000, mem_addr={src_ptr,2'b00}. On handshake, capture mem_rdata into the data register, src_ptr += 1 (word), go to WR.
- WR: mem_valid=1, mem_wstrb=1111, mem_addr={dst_ptr,2'b00}. mem_wdata = captured data (copy) or latched fill word (fill). On handshake, dst_ptr += 1 and remaining -= 1. If remaining was 1, go to DONE; else copy -> RD, fill -> WR.
- DONE: mem_valid=0, done=1 for exactly one cycle, busy=1. Next state IDLE, busy=0.
- Pointer arithmetic: 30-bit word pointers wrap modulo 2^30, so address 0xFFFFFFFC is followed by 0x00000000.
- Latency, zero-wait responder:
  - Copy of N words: 2N bus cycles, then the done cycle.
  - Fill of N words: N bus cycles, then the done cycle.
  - The first request is visible the cycle after the start edge.
- start while busy (any state other than IDLE): ignored; not queued.
- Input changes after acceptance (src_addr, dst_addr, len_words, mode, fill_data): no effect on the running transfer.
- Reset mid-transfer: at the next edge with resetn=0, return to IDLE and drop mem_valid, even mid-handshake. No done pulse. Memory is left partially written.
- Overlapping regions: copy proceeds in ascending word order. Overlap with dst > src is not corrected, by design.

Test Plan:
- Copy, zero-wait RAM model: copy len=4, src=0x100, dst=0x200, with RAM[0x100..0x10C]=A0..A3. Required: 8 consecutive mem_valid cycles alternating read/write, RAM[0x200..0x20C]=A0..A3, done exactly once in the 9th cycle after the start edge, then busy=0.
- Fill, unaligned and wrapping address: fill len=3, dst=0xFFFFFFFE, fill_data=0xDEADBEEF. Required: writes to 0xFFFFFFFC, 0x00000000, 0x00000004 with wstrb=1111; done on the 4th cycle.
- Zero length: len=0 with start. Required: mem_valid never asserts; done pulses in the cycle after the start edge.
- Wait states: responder delays mem_ready 3 cycles per request during a copy of len=2. Required: mem_addr, mem_wdata and mem_wstrb are stable across every stall; destination data is correct; done is delayed accordingly.
- start while busy: assert start with new parameters in the middle of a len=5 fill. Required: the second request is ignored; exactly 5 writes; a single done pulse.
- Reset mid-transfer: resetn=0 during the 2nd write of a len=4 copy. Required: next cycle mem_valid=0, busy=0, done=0. A subsequent start runs a complete, correct transfer.
